ev_counter_mc: RTL and testbench

//  Multi-channel edge-event counter: CH independent counters, each counting

---
 rtl/ev_counter_mc.sv | 122 ++++++++++++
 tb/tb_ev_counter_mc.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ev_counter_mc.sv
// Multi-channel edge-event counter with sync, per-channel clear, sticky ovf.
// Define EV_CNT_SAT_EN to saturate counters instead of wrapping.
module ev_counter_mc #(
  parameter int CH          = 4,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  localparam int SEL_W      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [CH-1:0]    ev_i,
  input  logic [1:0]       edge_mode_i,
  input  logic             en_i,
  input  logic [CH-1:0]    clr_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CH-1:0]    ovf_o
);

  logic [CH-1:0] s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = ev_i;
    end else begin : g_sync
      logic [CH-1:0] sync_q [SYNC_STAGES];
      logic [CH-1:0] sync_d [SYNC_STAGES];

      always_comb begin
        sync_d[0] = ev_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_d[i] = sync_q[i-1];
        end
      end

      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
          end
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic [CH-1:0]    evh_q, evh_d;
  logic [CH-1:0]    rise, fall, hit;
  logic [CNT_W-1:0] cnt_q [CH];
  logic [CNT_W-1:0] cnt_d [CH];
  logic [CH-1:0]    ovf_q, ovf_d;
  logic [CNT_W-1:0] rd_q, rd_d;

  // History always follows s so edges seen while disabled are consumed
  always_comb begin
    evh_d = s;
    rise  = s & ~evh_q;
    fall  = ~s & evh_q;
    case (edge_mode_i)
      2'b00:   hit = rise;
      2'b01:   hit = fall;
      2'b10:   hit = rise | fall;
      default: hit = '0;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    for (int n = 0; n < CH; n++) begin
      cnt_d[n] = cnt_q[n];
      if (clr_i[n]) begin
        cnt_d[n] = '0;
        ovf_d[n] = 1'b0;
      end else if (en_i && hit[n]) begin
        if (&cnt_q[n]) begin
          ovf_d[n] = 1'b1;
`ifdef EV_CNT_SAT_EN
          cnt_d[n] = cnt_q[n];
`else
          cnt_d[n] = '0;
`endif
        end else begin
          cnt_d[n] = cnt_q[n] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    rd_d = '0;
    if (int'(sel_i) < CH) begin
      rd_d = cnt_q[sel_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      evh_q <= '0;
      ovf_q <= '0;
      rd_q  <= '0;
      for (int n = 0; n < CH; n++) begin
        cnt_q[n] <= '0;
      end
    end else begin
      evh_q <= evh_d;
      ovf_q <= ovf_d;
      rd_q  <= rd_d;
      for (int n = 0; n < CH; n++) begin
        cnt_q[n] <= cnt_d[n];
      end
    end
  end

  assign cnt_o = rd_q;
  assign ovf_o = ovf_q;

endmodule

// File: tb/tb_ev_counter_mc.sv
// Scoreboard bench for ev_counter_mc (CH=4, CNT_W=4, SYNC_STAGES=2).
module tb_ev_counter_mc;

`ifdef EV_CNT_SAT_EN
  localparam logic [3:0] E_WRAP17 = 4'd15;
  localparam logic [3:0] E_CH3    = 4'd15;
`else
  localparam logic [3:0] E_WRAP17 = 4'd1;
  localparam logic [3:0] E_CH3    = 4'd1;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] ev_i;
  logic [1:0] edge_mode_i;
  logic       en_i;
  logic [3:0] clr_i;
  logic [1:0] sel_i;
  logic [3:0] cnt_o;
  logic [3:0] ovf_o;

  always #5 clk_i = ~clk_i;

  ev_counter_mc #(
    .CH(4), .CNT_W(4), .SYNC_STAGES(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ev_i(ev_i),
    .edge_mode_i(edge_mode_i), .en_i(en_i), .clr_i(clr_i),
    .sel_i(sel_i), .cnt_o(cnt_o), .ovf_o(ovf_o)
  );

  typedef struct {
    string      name;
    logic [3:0] cnt;
    logic [3:0] ovf;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   fails  = 0;

  always @(negedge clk_i) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      checks++;
      if (cnt_o !== mon_e.cnt) begin
        fails++;
        $display("FAIL %s cnt_o got %0d want %0d",
                 mon_e.name, cnt_o, mon_e.cnt);
      end
      checks++;
      if (ovf_o !== mon_e.ovf) begin
        fails++;
        $display("FAIL %s ovf_o got %b want %b",
                 mon_e.name, ovf_o, mon_e.ovf);
      end
    end
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wait_empty(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 8) begin
      @(negedge clk_i);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL %s timeout got %0d pending want 0", nm, q.size());
      q.delete();
    end
  endtask

  task automatic push(input string nm, input logic [3:0] c,
                      input logic [3:0] o);
    exp_t e;
    e.name = nm;
    e.cnt  = c;
    e.ovf  = o;
    q.push_back(e);
  endtask

  task automatic expect_ch(input string nm, input int ch,
                           input logic [3:0] c, input logic [3:0] o);
    sel_i = 2'(ch);
    nclk(4);
    @(posedge clk_i);
    #1 push(nm, c, o);
    wait_empty(nm);
  endtask

  task automatic pulse(input int ch);
    ev_i[ch] = 1'b1;
    nclk(3);
    ev_i[ch] = 1'b0;
    nclk(3);
  endtask

  task automatic clr_ch(input int ch);
    clr_i[ch] = 1'b1;
    nclk(1);
    clr_i[ch] = 1'b0;
    nclk(1);
  endtask

  initial begin
    rst_i = 1'b0;
    ev_i = '0;
    edge_mode_i = 2'b00;
    en_i = 1'b1;
    clr_i = '0;
    sel_i = '0;
    nclk(2);
    @(posedge clk_i);
    #1 push("reset", 4'd0, 4'b0000);
    wait_empty("reset");
    rst_i = 1'b1;
    nclk(2);

    // first rise on ch2: counter at k+2, readout at k+3
    sel_i = 2'd2;
    nclk(2);
    ev_i[2] = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 push("lat_k2", 4'd0, 4'b0000);
    wait_empty("lat_k2");
    @(posedge clk_i);
    #1 push("lat_k3", 4'd1, 4'b0000);
    wait_empty("lat_k3");
    ev_i[2] = 1'b0;
    nclk(3);
    for (int i = 0; i < 4; i++) pulse(2);
    expect_ch("ch2_five", 2, 4'd5, 4'b0000);
    expect_ch("ch0_idle", 0, 4'd0, 4'b0000);
    expect_ch("ch1_idle", 1, 4'd0, 4'b0000);
    expect_ch("ch3_idle", 3, 4'd0, 4'b0000);

    edge_mode_i = 2'b10;
    for (int i = 0; i < 3; i++) pulse(0);
    expect_ch("mode_both", 0, 4'd6, 4'b0000);
    clr_ch(0);
    edge_mode_i = 2'b01;
    for (int i = 0; i < 3; i++) pulse(0);
    expect_ch("mode_fall", 0, 4'd3, 4'b0000);
    clr_ch(0);
    edge_mode_i = 2'b11;
    for (int i = 0; i < 3; i++) pulse(0);
    expect_ch("mode_none", 0, 4'd0, 4'b0000);
    edge_mode_i = 2'b00;

    for (int i = 0; i < 17; i++) pulse(1);
    expect_ch("ovf_17", 1, E_WRAP17, 4'b0010);

    clr_ch(1);
    expect_ch("clr_ch1", 1, 4'd0, 4'b0000);
    for (int i = 0; i < 7; i++) pulse(1);
    expect_ch("ch1_seven", 1, 4'd7, 4'b0000);
    ev_i[1] = 1'b1;
    ev_i[3] = 1'b1;
    nclk(2);
    clr_i[1] = 1'b1;
    nclk(1);
    clr_i[1] = 1'b0;
    ev_i[1] = 1'b0;
    ev_i[3] = 1'b0;
    nclk(3);
    expect_ch("clr_wins", 1, 4'd0, 4'b0000);
    expect_ch("ch3_indep", 3, 4'd1, 4'b0000);
    expect_ch("ch2_kept", 2, 4'd5, 4'b0000);

    en_i = 1'b0;
    ev_i[0] = 1'b1;
    nclk(4);
    en_i = 1'b1;
    nclk(4);
    ev_i[0] = 1'b0;
    nclk(3);
    expect_ch("en_off", 0, 4'd0, 4'b0000);
    pulse(0);
    expect_ch("en_back", 0, 4'd1, 4'b0000);

    for (int i = 0; i < 16; i++) pulse(3);
    expect_ch("ch3_ovf", 3, E_CH3, 4'b1000);
    sel_i = 2'd2;
    nclk(3);
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    push("async_rst", 4'd0, 4'b0000);
    wait_empty("async_rst");
    nclk(2);
    rst_i = 1'b1;
    nclk(2);
    for (int c = 0; c < 4; c++) begin
      expect_ch($sformatf("post_rst_ch%0d", c), c, 4'd0, 4'b0000);
    end
    pulse(2);
    pulse(2);
    expect_ch("resume", 2, 4'd2, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
